rotation_fifo: RTL and testbench

Three-lane result buffer between the rotation CORDIC and the Jacobi main controller. It absorbs the CORDIC's x/y/z results, which arrive under valid only with no stall, and presents them to the controller over a valid/ready handshake. An almost-full flag lets the controller stop issuing new rotations before in-flight results could overflow the buffer. Storage is first-word-fall-through.

---
 rtl/common_pkg.sv | 14 +
 rtl/rotation_fifo_mem.sv | 23 ++
 rtl/rotation_fifo.sv | 88 ++++++++
 tb/tb_rotation_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// common: shared Jacobi datapath constants and types
package common;

    localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
    localparam int JACOBI_ROT_FIFO_DEPTH    = 32;
    localparam int JACOBI_ROT_FIFO_AFULL    = 16;

    typedef struct packed {
        logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] x;
        logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] y;
        logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] z;
    } rot_triplet_t;

endpackage

// File: rtl/rotation_fifo_mem.sv
// rotation_fifo_mem: register array, synchronous write, asynchronous read
module rotation_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [3*WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [3*WIDTH-1:0]         rd_data
);

    logic [3*WIDTH-1:0] mem [DEPTH];

    // write the incoming triplet; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rotation_fifo.sv
// rotation_fifo: first-word-fall-through x/y/z buffer from the CORDIC to the controller
module rotation_fifo
    import common::*;
#(
    parameter int WIDTH       = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int DEPTH       = JACOBI_ROT_FIFO_DEPTH,
    parameter int AFULL_LEVEL = JACOBI_ROT_FIFO_AFULL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             in_dat_x_i,
    input  logic [WIDTH-1:0]             in_dat_y_i,
    input  logic [WIDTH-1:0]             in_dat_z_i,
    input  logic                         in_vld_i,
    output logic [WIDTH-1:0]             out_dat_x_o,
    output logic [WIDTH-1:0]             out_dat_y_o,
    output logic [WIDTH-1:0]             out_dat_z_o,
    output logic                         out_vld_o,
    input  logic                         out_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         afull_o,
    output logic                         overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [1:0]         rst_sync;
    logic               rst_n_int;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic               overflow;
    logic               full, pop, push_ok, drop;
    logic [3*WIDTH-1:0] rd_word;

    // assert asynchronously, release two edges after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    assign full    = level == LW'(DEPTH);
    assign pop     = out_vld_o && out_rdy_i && !flush_i;
    assign push_ok = in_vld_i && !flush_i && (!full || pop);
    assign drop    = in_vld_i && !flush_i && full && !pop;

    // pointers, occupancy and sticky overflow; flush outranks push and pop
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push_ok != pop) level <= push_ok ? level + LW'(1) : level - LW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // lane order matches rot_triplet_t: x in the top bits
    rotation_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we      (push_ok && rst_n_int),
        .wr_addr (wr_ptr),
        .wr_data ({in_dat_x_i, in_dat_y_i, in_dat_z_i}),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign out_dat_x_o = rd_word[3*WIDTH-1:2*WIDTH];
    assign out_dat_y_o = rd_word[2*WIDTH-1:WIDTH];
    assign out_dat_z_o = rd_word[WIDTH-1:0];
    assign out_vld_o   = level != '0;
    assign level_o     = level;
    assign afull_o     = level >= LW'(AFULL_LEVEL);
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_rotation_fifo.sv
// tb_rotation_fifo: directed vectors and corner sequences for rotation_fifo
module tb_rotation_fifo;
    import common::*;

    localparam int W  = JACOBI_OUTPUT_WORD_WIDTH;
    localparam int LW = 6;

    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, vld = 1'b0, rdy = 1'b0;
    logic [W-1:0] ix = '0, iy = '0, iz = '0, ox, oy, oz;
    logic ov, af, of;
    logic [LW-1:0] lvl;
    int nv = 0, nerr = 0;

    typedef struct {
        logic f, v, r;
        logic [W-1:0] d;
        logic ev;
        int el;
        logic ea, eo;
        logic [W-1:0] ex;
    } vec_t;

    vec_t tv[6];

    always #5 clk = ~clk;

    rotation_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_dat_x_i  (ix),
        .in_dat_y_i  (iy),
        .in_dat_z_i  (iz),
        .in_vld_i    (vld),
        .out_dat_x_o (ox),
        .out_dat_y_o (oy),
        .out_dat_z_o (oz),
        .out_vld_o   (ov),
        .out_rdy_i   (rdy),
        .level_o     (lvl),
        .afull_o     (af),
        .overflow_o  (of)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        nv++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic r, input logic [W-1:0] d);
        flush = f;
        vld   = v;
        rdy   = r;
        ix    = d;
        iy    = d + W'(1);
        iz    = d + W'(2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{1'b0, 1'b0, 1'b0, W'(0), 1'b0, 0, 1'b0, 1'b0, W'(0)};
        tv[1] = '{1'b0, 1'b1, 1'b0, W'(1), 1'b1, 1, 1'b0, 1'b0, W'(1)};
        tv[2] = '{1'b0, 1'b0, 1'b1, W'(0), 1'b0, 0, 1'b0, 1'b0, W'(0)};
        tv[3] = '{1'b0, 1'b1, 1'b1, W'(5), 1'b1, 1, 1'b0, 1'b0, W'(5)};
        tv[4] = '{1'b0, 1'b1, 1'b1, W'(6), 1'b1, 1, 1'b0, 1'b0, W'(6)};
        tv[5] = '{1'b0, 1'b0, 1'b1, W'(0), 1'b0, 0, 1'b0, 1'b0, W'(0)};

        #12 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", lvl, 0);
        chk("reset_vld", ov, 0);
        chk("reset_afull", af, 0);
        chk("reset_ovf", of, 0);

        for (int i = 0; i < 6; i++) begin
            cyc(tv[i].f, tv[i].v, tv[i].r, tv[i].d);
            chk($sformatf("tbl%0d_vld", i), ov, tv[i].ev);
            chk($sformatf("tbl%0d_level", i), lvl, tv[i].el);
            chk($sformatf("tbl%0d_afull", i), af, tv[i].ea);
            chk($sformatf("tbl%0d_ovf", i), of, tv[i].eo);
            if (tv[i].ev) begin
                chk($sformatf("tbl%0d_x", i), ox, tv[i].ex);
                chk($sformatf("tbl%0d_y", i), oy, tv[i].ex + W'(1));
                chk($sformatf("tbl%0d_z", i), oz, tv[i].ex + W'(2));
            end
        end

        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 1'b1, 1'b0, W'(k));
            chk($sformatf("fill%0d_level", k), lvl, k + 1);
            chk($sformatf("fill%0d_afull", k), af, (k + 1) >= 16);
            chk($sformatf("fill%0d_head", k), ox, 0);
        end
        cyc(1'b0, 1'b1, 1'b0, W'(77));
        chk("ovf_level", lvl, 32);
        chk("ovf_flag", of, 1);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("drain%0d_head", k), ox, k);
            cyc(1'b0, 1'b0, 1'b1, W'(0));
            chk($sformatf("drain%0d_level", k), lvl, 31 - k);
        end
        chk("drain_vld", ov, 0);
        chk("drain_ovf_sticky", of, 1);

        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, W'(200 + k));
        chk("preflush_level", lvl, 10);
        chk("preflush_ovf", of, 1);
        cyc(1'b1, 1'b1, 1'b1, W'(555));
        chk("flush_level", lvl, 0);
        chk("flush_vld", ov, 0);
        chk("flush_ovf", of, 0);
        chk("flush_afull", af, 0);
        cyc(1'b0, 1'b1, 1'b0, W'(7));
        chk("postflush_level", lvl, 1);
        chk("postflush_x", ox, 7);
        chk("postflush_y", oy, 8);
        cyc(1'b0, 1'b0, 1'b1, W'(0));
        chk("postflush_empty", lvl, 0);

        for (int k = 0; k < 32; k++) cyc(1'b0, 1'b1, 1'b0, W'(100 + k));
        chk("full_level", lvl, 32);
        cyc(1'b0, 1'b1, 1'b1, W'(99));
        chk("fullpp_level", lvl, 32);
        chk("fullpp_ovf", of, 0);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("fullpp%0d_head", k), ox, k < 31 ? 101 + k : 99);
            cyc(1'b0, 1'b0, 1'b1, W'(0));
        end
        chk("fullpp_empty", lvl, 0);

        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, W'(1000 + k));
        for (int j = 0; j < 100; j++) begin
            chk($sformatf("wrap%0d_head", j), ox, 1000 + j);
            cyc(1'b0, 1'b1, 1'b1, W'(1005 + j));
            chk($sformatf("wrap%0d_level", j), lvl, 5);
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrapdrain%0d_head", k), ox, 1100 + k);
            cyc(1'b0, 1'b0, 1'b1, W'(0));
        end
        chk("wrap_empty", lvl, 0);

        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, W'(300 + k));
        chk("prerst_level", lvl, 7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_level", lvl, 0);
        chk("async_rst_vld", ov, 0);
        chk("async_rst_ovf", of, 0);
        vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, W'(400));
        chk("release_first_push", lvl, 0);
        cyc(1'b0, 1'b0, 1'b0, W'(0));
        cyc(1'b0, 1'b1, 1'b0, W'(401));
        chk("release_push_level", lvl, 1);
        chk("release_push_x", ox, 401);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
